comparator_seq_ctrl: RTL and testbench

Sequencer that compares two WIDTH-bit unsigned operands by time-multiplexing a single `comparator_4_bit` instance over WIDTH/4 cycles. It works from least-significant nibble upward and feeds each nibble's result into the cascade inputs of the next. It sits between a requester issuing start/operand pairs and the shared 4-bit comparator, trading latency for area in wide-compare paths. Final gt/eq/lt flags are registered and held until the next accepted start.

---
 rtl/comparator_pkg.sv | 27 ++
 rtl/comparator_4_bit.sv | 28 ++
 rtl/comparator_seq_ctrl.sv | 106 ++++++++++
 tb/tb_comparator_seq_ctrl.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/comparator_pkg.sv
// Shared types and constants for the nibble-serial magnitude comparator.
package comparator_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int NIB_W = 4;

    localparam logic [2:0] CASC_GT = 3'b100;
    localparam logic [2:0] CASC_EQ = 3'b010;
    localparam logic [2:0] CASC_LT = 3'b001;

    // Anything other than a single asserted flag is treated as "equal so far".
    function automatic logic [2:0] casc_norm(input logic [2:0] c);
        logic [2:0] r;
        r = CASC_EQ;
        unique case (c)
            CASC_GT, CASC_EQ, CASC_LT: r = c;
            default:                   r = CASC_EQ;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/comparator_4_bit.sv
// 4-bit unsigned magnitude comparator with cascade inputs.
module comparator_4_bit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       i_a_gt_b,
    input  logic       i_a_eq_b,
    input  logic       i_a_lt_b,
    output logic       o_a_gt_b,
    output logic       o_a_eq_b,
    output logic       o_a_lt_b
);

    always_comb begin
        o_a_gt_b = 1'b0;
        o_a_eq_b = 1'b0;
        o_a_lt_b = 1'b0;
        if (a > b) begin
            o_a_gt_b = 1'b1;
        end else if (a < b) begin
            o_a_lt_b = 1'b1;
        end else begin
            o_a_gt_b = i_a_gt_b;
            o_a_eq_b = i_a_eq_b;
            o_a_lt_b = i_a_lt_b;
        end
    end

endmodule

// File: rtl/comparator_seq_ctrl.sv
// Wide unsigned compare by walking one shared 4-bit comparator
// from the low nibble upward, one nibble per cycle.
module comparator_seq_ctrl
    import comparator_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             i_a_gt_b,
    input  logic             i_a_eq_b,
    input  logic             i_a_lt_b,
    output logic             o_ready,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_a_gt_b,
    output logic             o_a_eq_b,
    output logic             o_a_lt_b
);

    localparam int N  = WIDTH / NIB_W;
    localparam int SW = (N > 1) ? $clog2(N) : 1;

    state_e           state_q, state_d;
    logic [SW-1:0]    step_q, step_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [2:0]       casc_q, casc_d;
    logic [2:0]       flags_q, flags_d;

    logic [WIDTH-1:0] a_sh, b_sh;
    logic [2:0]       cmp_out;

    assign a_sh = a_q >> {step_q, 2'b00};
    assign b_sh = b_q >> {step_q, 2'b00};

    comparator_4_bit u_cmp (
        .a        (a_sh[NIB_W-1:0]),
        .b        (b_sh[NIB_W-1:0]),
        .i_a_gt_b (casc_q[2]),
        .i_a_eq_b (casc_q[1]),
        .i_a_lt_b (casc_q[0]),
        .o_a_gt_b (cmp_out[2]),
        .o_a_eq_b (cmp_out[1]),
        .o_a_lt_b (cmp_out[0])
    );

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        a_d     = a_q;
        b_d     = b_q;
        casc_d  = casc_q;
        flags_d = flags_q;
        unique case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (i_start) begin
                    a_d     = a;
                    b_d     = b;
                    casc_d  = casc_norm({i_a_gt_b, i_a_eq_b, i_a_lt_b});
                    step_d  = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                casc_d = cmp_out;
                step_d = step_q + SW'(1);
                if (step_q == SW'(N - 1)) begin
                    flags_d = cmp_out;
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            step_q  <= '0;
            a_q     <= '0;
            b_q     <= '0;
            casc_q  <= '0;
            flags_q <= '0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            a_q     <= a_d;
            b_q     <= b_d;
            casc_q  <= casc_d;
            flags_q <= flags_d;
        end
    end

    assign o_ready  = (state_q != RUN);
    assign o_busy   = (state_q == RUN);
    assign o_done   = (state_q == DONE);
    assign o_a_gt_b = flags_q[2];
    assign o_a_eq_b = flags_q[1];
    assign o_a_lt_b = flags_q[0];

endmodule

// File: tb/tb_comparator_seq_ctrl.sv
// Scoreboard bench for comparator_seq_ctrl: randomized and directed
// starts, reference results from plain integer comparison.
module tb_comparator_seq_ctrl;

    localparam int WIDTH = 16;
    localparam int N     = WIDTH / 4;

    typedef struct {
        logic [2:0] f;
        int         due;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             i_start = 1'b0;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic             i_a_gt_b = 1'b0;
    logic             i_a_eq_b = 1'b1;
    logic             i_a_lt_b = 1'b0;
    logic             o_ready, o_busy, o_done;
    logic             o_a_gt_b, o_a_eq_b, o_a_lt_b;

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    exp_t q[$];
    logic [2:0] last_flags = 3'b000;

    comparator_seq_ctrl #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_start  (i_start),
        .a        (a),
        .b        (b),
        .i_a_gt_b (i_a_gt_b),
        .i_a_eq_b (i_a_eq_b),
        .i_a_lt_b (i_a_lt_b),
        .o_ready  (o_ready),
        .o_busy   (o_busy),
        .o_done   (o_done),
        .o_a_gt_b (o_a_gt_b),
        .o_a_eq_b (o_a_eq_b),
        .o_a_lt_b (o_a_lt_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [2:0] model(input logic [WIDTH-1:0] x,
                                         input logic [WIDTH-1:0] y,
                                         input logic [2:0] c);
        int unsigned xi, yi;
        xi = x;
        yi = y;
        if (xi > yi) return 3'b100;
        if (xi < yi) return 3'b001;
        if ($countones(c) == 1) return c;
        return 3'b010;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops the scoreboard on every o_done, otherwise checks flag hold.
    always @(negedge clk) begin
        if (!rst_n) begin
            last_flags = 3'b000;
            check("reset_outputs",
                  {o_done, o_busy, o_ready, o_a_gt_b, o_a_eq_b, o_a_lt_b},
                  6'b001000);
        end else begin
            check("ready_vs_busy", o_ready, !o_busy);
            if (o_done) begin
                if (q.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    check("result_flags", {o_a_gt_b, o_a_eq_b, o_a_lt_b}, e.f);
                    check("done_cycle", cyc, e.due);
                    last_flags = e.f;
                end
            end else begin
                check("flags_hold", {o_a_gt_b, o_a_eq_b, o_a_lt_b}, last_flags);
            end
        end
    end

    // Called at a negedge; returns #1 after the sampling edge.
    task automatic drive(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                         input logic [2:0] c);
        exp_t e;
        a = av;
        b = bv;
        {i_a_gt_b, i_a_eq_b, i_a_lt_b} = c;
        i_start = 1'b1;
        if (o_ready) begin
            e.f   = model(av, bv, c);
            e.due = cyc + 1 + N;
            q.push_back(e);
        end
        @(posedge clk);
        #1 i_start = 1'b0;
    endtask

    task automatic wait_ready();
        bit ok = 0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (o_ready) ok = 1;
        end
        if (!ok) check("ready_timeout", 0, 1);
    endtask

    task automatic wait_done();
        bit ok = 0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            if (o_done) ok = 1;
        end
        if (!ok) check("done_timeout", 0, 1);
    endtask

    initial begin
        logic [WIDTH-1:0] ra, rb;
        logic [2:0]       rc;
        bit               drained;

        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;

        // Reset mid-run aborts the comparison.
        @(negedge clk);
        drive(16'h1234, 16'h1234, 3'b010);
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        q.delete();
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        drive(16'h1234, 16'h1234, 3'b010);

        wait_ready();
        drive(16'h8000, 16'h7FFF, 3'b010);
        wait_ready();
        drive(16'h0001, 16'h0002, 3'b010);
        wait_ready();
        drive(16'hFFFF, 16'hFFFF, 3'b010);
        wait_ready();
        drive(16'h5A5A, 16'h5A5A, 3'b100);
        wait_ready();
        drive(16'h5A5A, 16'h5A5A, 3'b111);

        // Busy rejection: second start lands on step 2.
        wait_ready();
        drive(16'h0003, 16'h0002, 3'b010);
        repeat (3) @(negedge clk);
        drive(16'h0000, 16'hFFFF, 3'b010);

        // Back-to-back start in the DONE cycle.
        wait_done();
        drive(16'h0010, 16'h0100, 3'b010);

        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 2) == 0) wait_done();
            else wait_ready();
            ra = WIDTH'($urandom);
            rb = ($urandom_range(0, 3) == 0) ? ra : WIDTH'($urandom);
            if ($urandom_range(0, 1) == 1) rb[3:0] = ra[3:0];
            rc = 3'($urandom);
            drive(ra, rb, rc);
        end

        drained = 0;
        for (int i = 0; i < 100 && !drained; i++) begin
            @(negedge clk);
            if (q.size() == 0) drained = 1;
        end
        if (!drained) check("drain_timeout", 0, 1);
        repeat (4) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
